seg_scroll_mux: RTL and testbench
=================================

# seg_scroll_mux

Parametrised scrolling seven-segment display engine: holds a MSG_DIGITS-nibble message, rotates it one digit per step period in a selectable direction, exposes a WIN_DIGITS-digit window, and time-multiplexes that window onto a common-anode digit bank with hex-to-segment decoding. It sits between message-producing logic and the board's `an`/`seg` pins. Pause, reload and direction control are available at run time.

## Interface
- MSG_DIGITS, 10, message length in hex digits; legal range ≥ WIN_DIGITS.
- WIN_DIGITS, 4, displayed window width in digits; legal range ≥ 1.
- STEP_DIV, 25000000, clk cycles per scroll step; legal range ≥ 2.
- SCAN_DIV, 50000, clk cycles per digit scan slot; legal range ≥ 2.
- ACTIVE_LOW_SEG, 1, 1 = `seg` is active-low, 0 = active-high. `an` is always active-low.
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  1-cycle strobe: capture `msg_in`.
- msg_in  in  4*MSG_DIGITS  new message; nibble MSG_DIGITS-1 (MSBs) is the leftmost digit.
- run  in  1  1 = step counter advances, 0 = paused.
- dir  in  1  0 = scroll left (rotate msg left by 4), 1 = scroll right (rotate right by 4).
- data  out  4*WIN_DIGITS  current window, equal to msg[4*MSG_DIGITS-1 -: 4*WIN_DIGITS].
- step_tick  out  1  high for exactly one cycle, coincident with the first cycle showing the rotated msg.
- an  out  WIN_DIGITS  digit enables; `an[i]` low selects digit i; i=0 is the rightmost digit (data[3:0]).
- seg  out  8  {dp,g,f,e,d,c,b,a}; dp is always off.

## Operation
- Message register `msg` (4*MSG_DIGITS bits), reset 0.
- Step counter `scnt` 0..STEP_DIV-1, reset 0:
  - When run=1: increments each cycle.
  - At STEP_DIV-1: wraps to 0 and performs a rotate.
  - When run=0: holds its value, and no rotate occurs.
- Rotate:
  - dir=0: msg <= {msg[4M-5:0], msg[4M-1:4M-4]}.
  - dir=1: msg <= {msg[3:0], msg[4M-1:4]}.
  - `dir` is sampled on the rotate cycle only.
- Load has priority: when load=1, msg <= msg_in, scnt <= 0, and no rotate occurs, even if scnt==STEP_DIV-1 with run=1. In that case step_tick stays 0.
- `data` is a direct slice of `msg`, with no extra register stage.
- Scan counter `qcnt` 0..SCAN_DIV-1 is free-running, independent of run and load. On wrap, digit index `idx` advances 0→1→…→WIN_DIGITS-1→0.
- Registered outputs, every cycle:
  - an <= ~(1<<idx).
  - seg <= decode(data[4*idx+3 -: 4]), inverted when ACTIVE_LOW_SEG=1, with dp off.
- Hex decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- MSG_DIGITS == WIN_DIGITS is legal: the window is the whole message and rotation is still visible.

## Timing
- Reset values:
  - msg=0, data=0, scnt=0, qcnt=0, idx=0, step_tick=0.
  - an = all ones (all digits off).
  - seg = all segments off: 8'hFF for active-low, 8'h00 for active-high.
- Load latency: load sampled at edge E0; data = msg_in from E0 onward.
- Step timing: with run held at 1 after load, rotates occur at E0+STEP_DIV, E0+2·STEP_DIV, and so on. step_tick is high during the cycle after each of those edges.
- Pause: dropping run for k cycles delays every subsequent rotate by exactly k cycles.
- Scan timing:
  - Each digit is enabled for exactly SCAN_DIV cycles.
  - an/seg lag idx/data by 1 cycle.
  - A data change mid-slot appears on seg one cycle later.
- Reset mid-operation: all state returns to reset values asynchronously. The first scan slot after release is idx=0, lasting SCAN_DIV cycles.

## Test plan
Parameters: MSG_DIGITS=10, WIN_DIGITS=4, STEP_DIV=4, SCAN_DIV=3, ACTIVE_LOW_SEG=1.
- Reset: assert rst_n=0 → data=16'h0000, an=4'b1111, seg=8'hFF, step_tick=0, all immediately (asynchronous).
- Left scroll: load 40'h1234567890 with run=1, dir=0 → data=16'h1234 after the load edge. step_tick pulses every 4 cycles. data sequence: 2345, 3456, …; after 10 steps, back to 1234.
- Right scroll: load the same message, dir=1 → after the first step data=16'h0123, then 16'h9012.
- Pause: run=0 for 5 cycles when scnt=2 → next rotate occurs 2+5 cycles later, with no step_tick during the pause.
- Load/step collision: assert load on the cycle where scnt=3 and run=1, with msg_in=40'hABCDEF0123 → data=16'hABCD, step_tick=0, next rotate 4 cycles later giving 16'hBCDE.
- Scan: with data=16'h1234 → an cycles 1110, 1101, 1011, 0111, each for 3 cycles. seg follows 8'h99 (digit 4), 8'hB0 (digit 3), 8'hA4 (digit 2), 8'hF9 (digit 1).

Source files
------------

// File: rtl/seg_scroll_mux.sv
// Scrolling seven-segment engine: rotating hex message, WIN_DIGITS window,
// and a common-anode digit scanner with hex-to-segment decoding.
module seg_scroll_mux #(
  parameter int MSG_DIGITS     = 10,
  parameter int WIN_DIGITS     = 4,
  parameter int STEP_DIV       = 25000000,
  parameter int SCAN_DIV       = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*MSG_DIGITS-1:0] msg_in,
  input  logic                    run,
  input  logic                    dir,
  output logic [4*WIN_DIGITS-1:0] data,
  output logic                    step_tick,
  output logic [WIN_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int MW = 4 * MSG_DIGITS;
  localparam int SW = $clog2(STEP_DIV);
  localparam int QW = $clog2(SCAN_DIV);
  localparam int IW = (WIN_DIGITS > 1) ? $clog2(WIN_DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;

  logic [MW-1:0]   msg;
  logic [SW-1:0]   scnt;
  logic [QW-1:0]   qcnt;
  logic [IW-1:0]   idx;
  logic [2*MW-1:0] dbl, shl, shr;
  logic [MW-1:0]   rot_l, rot_r;
  logic [3:0]      nib;
  logic [6:0]      dec;

  assign data = msg[MW-1 -: 4*WIN_DIGITS];

  // Rotations taken from a doubled message so a single-digit message stays legal.
  always_comb begin
    dbl   = {msg, msg};
    shl   = dbl >> (MW - 4);
    shr   = dbl >> 4;
    rot_l = shl[MW-1:0];
    rot_r = shr[MW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg       <= '0;
      scnt      <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (load) begin
        msg  <= msg_in;
        scnt <= '0;
      end else if (run) begin
        if (scnt == SW'(STEP_DIV - 1)) begin
          scnt      <= '0;
          step_tick <= 1'b1;
          msg       <= dir ? rot_r : rot_l;
        end else begin
          scnt <= scnt + SW'(1);
        end
      end
    end
  end

  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < WIN_DIGITS; i++) begin
      if (idx == IW'(i)) nib = data[4*i +: 4];
    end
    case (nib)
      4'h0: dec = 7'h3F;
      4'h1: dec = 7'h06;
      4'h2: dec = 7'h5B;
      4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;
      4'h5: dec = 7'h6D;
      4'h6: dec = 7'h7D;
      4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;
      4'h9: dec = 7'h6F;
      4'hA: dec = 7'h77;
      4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;
      4'hD: dec = 7'h5E;
      4'hE: dec = 7'h79;
      default: dec = 7'h71;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0;
      idx  <= '0;
      an   <= '1;
      seg  <= SEG_OFF;
    end else begin
      if (qcnt == QW'(SCAN_DIV - 1)) begin
        qcnt <= '0;
        idx  <= (idx == IW'(WIN_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        qcnt <= qcnt + QW'(1);
      end
      an  <= ~(WIN_DIGITS'(1) << idx);
      seg <= ACTIVE_LOW_SEG ? {1'b1, ~dec} : {1'b0, dec};
    end
  end

endmodule

// File: tb/tb_seg_scroll_mux.sv
// Directed bench for seg_scroll_mux with short step/scan periods.
module tb_seg_scroll_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [39:0] msg_in;
  logic        run;
  logic        dir;
  logic [15:0] data;
  logic        step_tick;
  logic [3:0]  an;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  seg_scroll_mux #(
    .MSG_DIGITS(10),
    .WIN_DIGITS(4),
    .STEP_DIV(4),
    .SCAN_DIV(3),
    .ACTIVE_LOW_SEG(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .msg_in(msg_in),
    .run(run),
    .dir(dir),
    .data(data),
    .step_tick(step_tick),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [39:0] m, input logic r, input logic d);
    load = 1'b1; msg_in = m; run = r; dir = d;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_load(40'h1234567890, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=%h", data, 16'h0000); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=%b", an, 4'b1111); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=%h", seg, 8'hFF); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", step_tick); end
    tick();
  endtask

  task automatic test_scan();
    logic [7:0] seg_tab [4];
    logic [3:0] an_exp;
    seg_tab[0] = 8'h99; seg_tab[1] = 8'hB0; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hF9;
    // release reset and load in the same cycle; first edge loads the message
    rst_n = 1'b1;
    do_load(40'h1234000000, 1'b0, 1'b0);
    checks++; if (data !== 16'h1234) begin errors++; $display("FAIL scan_data got=%h exp=%h", data, 16'h1234); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL scan_an1 got=%b exp=%b", an, 4'b1110); end
    checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL scan_seg_lag got=%h exp=%h", seg, 8'hC0); end
    for (int k = 2; k <= 13; k++) begin
      tick();
      an_exp = ~(4'b0001 << (((k - 1) / 3) % 4));
      checks++; if (an !== an_exp) begin errors++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, an, an_exp); end
      checks++; if (seg !== seg_tab[((k - 1) / 3) % 4]) begin errors++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, seg_tab[((k - 1) / 3) % 4]); end
    end
  endtask

  task automatic test_left();
    logic [15:0] seq [10];
    seq[0] = 16'h2345; seq[1] = 16'h3456; seq[2] = 16'h4567; seq[3] = 16'h5678; seq[4] = 16'h6789;
    seq[5] = 16'h7890; seq[6] = 16'h8901; seq[7] = 16'h9012; seq[8] = 16'h0123; seq[9] = 16'h1234;
    do_load(40'h1234567890, 1'b1, 1'b0);
    checks++; if (data !== 16'h1234) begin errors++; $display("FAIL left_load got=%h exp=%h", data, 16'h1234); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL left_load_tick got=%b exp=0", step_tick); end
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL left_idle_tick s=%0d got=%b exp=0", s, step_tick); end
      end
      tick();
      checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL left_tick s=%0d got=%b exp=1", s, step_tick); end
      checks++; if (data !== seq[s]) begin errors++; $display("FAIL left_data s=%0d got=%h exp=%h", s, data, seq[s]); end
    end
  endtask

  task automatic test_right();
    do_load(40'h1234567890, 1'b1, 1'b1);
    tick(); tick(); tick();
    checks++; if (data !== 16'h1234) begin errors++; $display("FAIL right_hold got=%h exp=%h", data, 16'h1234); end
    tick();
    checks++; if (data !== 16'h0123) begin errors++; $display("FAIL right_1 got=%h exp=%h", data, 16'h0123); end
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL right_tick got=%b exp=1", step_tick); end
    tick(); tick(); tick(); tick();
    checks++; if (data !== 16'h9012) begin errors++; $display("FAIL right_2 got=%h exp=%h", data, 16'h9012); end
  endtask

  task automatic test_pause();
    do_load(40'h1234567890, 1'b1, 1'b0);
    tick(); tick();
    run = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL pause_tick c=%0d got=%b exp=0", c, step_tick); end
      checks++; if (data !== 16'h1234) begin errors++; $display("FAIL pause_data c=%0d got=%h exp=%h", c, data, 16'h1234); end
    end
    run = 1'b1;
    tick();
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL pause_early got=%b exp=0", step_tick); end
    tick();
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL pause_resume_tick got=%b exp=1", step_tick); end
    checks++; if (data !== 16'h2345) begin errors++; $display("FAIL pause_resume_data got=%h exp=%h", data, 16'h2345); end
  endtask

  task automatic test_collision();
    do_load(40'h1234567890, 1'b1, 1'b0);
    tick(); tick(); tick();
    do_load(40'hABCDEF0123, 1'b1, 1'b0);
    checks++; if (data !== 16'hABCD) begin errors++; $display("FAIL coll_data got=%h exp=%h", data, 16'hABCD); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL coll_tick got=%b exp=0", step_tick); end
    tick(); tick(); tick();
    checks++; if (step_tick !== 1'b0 || data !== 16'hABCD) begin errors++; $display("FAIL coll_early got=%b/%h exp=0/%h", step_tick, data, 16'hABCD); end
    tick();
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL coll_next_tick got=%b exp=1", step_tick); end
    checks++; if (data !== 16'hBCDE) begin errors++; $display("FAIL coll_next_data got=%h exp=%h", data, 16'hBCDE); end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; msg_in = '0; run = 1'b0; dir = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_scan();
    test_left();
    test_right();
    test_pause();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
